req_pending_arb: RTL
====================

Name: req_pending_arb

Overview:
- Upstream request-collection stage for the 8-to-3 priority encoding path.
- Captures request pulses from 8 sources into a sticky pending register, applies a mask, and selects the highest pending index (bit 7 highest, bit 0 lowest).
- Presents the selected index on a valid/ready handshake and clears the pending bit on acceptance.
- Exposes the masked pending vector so the downstream priority encoder can be driven directly.

Parameters:
- N, 8, number of request sources; fixed at 8 in this revision.
- IDX_W, 3, index width, equal to log2(N).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  8  request lines; a 0->1 transition posts a request.
- mask  input  8  1 = source masked (held pending, not selected).
- out_ready  input  1  consumer accepts out_idx this cycle.
- ovf_clr  input  1  clears all overflow flags.
- out_valid  output  1  out_idx holds a granted request.
- out_idx  output  3  granted source index.
- pend_vec  output  8  pending & ~mask; direct input to the encoder.
- ovf_flags  output  8  sticky per-source overflow.

Behaviour:
- Reset: pending=0, req_d=0, ovf_flags=0, out_valid=0, out_idx=0, state=IDLE.
  - A req_in bit high on the first cycle after reset counts as a rising edge.
- Edge detection:
  - rise = req_in & ~req_d; req_d <= req_in every cycle.
  - pending[i] <= 1 on rise[i].
- Clear: pending[out_idx] <= 0 on a handshake (out_valid & out_ready).
  - If rise[out_idx] occurs in the handshake cycle, set wins: the bit stays pending and no overflow is flagged.
- Overflow: rise[i] while pending[i]=1 and bit i is not being cleared sets ovf_flags[i].
  - ovf_clr clears all flags; a simultaneous new overflow wins for its bit.
- eligible = pending & ~mask; pend_vec = eligible, combinational from registers.
- FSM, 2 states:
  - IDLE: out_valid=0. If eligible != 0, register out_idx = highest set bit of eligible, set out_valid, go to PRESENT.
  - PRESENT: out_valid=1, and out_idx is frozen. Higher-priority arrivals, mask changes, or masking of the presented bit do not retract or alter it.
    - On handshake, let next = eligible with bit out_idx cleared.
    - If next != 0: load out_idx = highest bit of next, stay in PRESENT (back-to-back, no bubble).
    - Else: out_valid <= 0, go to IDLE.
- Latency: rise sampled at edge k -> pending visible after k -> out_valid after edge k+1 (2 cycles from request to valid).
- Throughput: one grant per cycle while out_ready=1 and requests remain.
- rst asserted mid-handshake: all state is discarded and no grant is accepted that cycle.
- Masked pending bits remain pending indefinitely and become eligible once unmasked.

Optional Feature:
- Macro: REQ_PEND_OVF_DETECT_EN.
- Defined: overflow detection and ovf_clr as described above.
- Undefined: no overflow logic; ovf_flags is constant 0 and ovf_clr is ignored. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req_in=0 -> out_valid=0, out_idx=0, pend_vec=0x00, ovf_flags=0x00.
- Single request: req_in 0x00->0x08 at edge k, out_ready=1 -> out_valid=1, out_idx=3 after edge k+1; handshake clears it; pend_vec=0x00 and out_valid=0 after the next edge.
- Priority and back-to-back: same-cycle rise 0x81, out_ready=1 -> out_idx=7 for one cycle, then 0 the next cycle with out_valid held; then out_valid=0.
- Freeze and mask: out_ready=0, idx 2 presented, then rise on bit 6 and mask=0x04 -> out_idx stays 2; after ready=1 it accepts 2, then presents 6; a masked bit 1 stays in pending but is never granted until mask=0x00.
- Overflow: bit 5 pending, out_ready=0, req_in[5] toggles 1->0->1 -> ovf_flags=0x20; ovf_clr=1 -> 0x00; with macro undefined -> stays 0x00.
- Set-wins collision: handshake on idx 4 in the same cycle as a new rise[4] -> pend_vec[4]=1 after the edge, ovf_flags[4]=0, and idx 4 is re-presented.

Source files
------------

// File: rtl/req_pending_arb.sv
// Purpose: sticky per-source request capture with mask; grants the highest eligible index over valid/ready.
// Latency: request rising edge to out_valid is 2 cycles; back-to-back grants with no bubble while ready stays high.
// Backpressure: out_idx is frozen while out_valid & ~out_ready; new requests keep accumulating in the pending register.
// Optional: define REQ_PEND_OVF_DETECT_EN to build the sticky per-source overflow flags (otherwise ovf_flags = 0).
module req_pending_arb #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask,
    input  logic             out_ready,
    input  logic             ovf_clr,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pend_vec,
    output logic [N-1:0]     ovf_flags
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state_q;
    logic [N-1:0]     req_q;
    logic [N-1:0]     pending_q;
    logic [N-1:0]     pending_d;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;

    logic [N-1:0]     rise;
    logic             hs;
    logic [N-1:0]     clr_vec;
    logic [N-1:0]     eligible;
    logic [N-1:0]     next_vec;

    // Highest set bit wins; returns 0 for an all-zero vector (callers gate on non-zero).
    function automatic logic [IDX_W-1:0] hi_idx(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Edge detect, pending update (set beats clear) and candidate for the back-to-back grant.
    always_comb begin
        rise      = req_in & ~req_q;
        hs        = out_valid_q & out_ready;
        clr_vec   = hs ? (N'(1) << out_idx_q) : '0;
        pending_d = (pending_q & ~clr_vec) | rise;
        eligible  = pending_q & ~mask;
        next_vec  = eligible & ~(N'(1) << out_idx_q);
    end

    // Request history and sticky pending bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            pending_q <= '0;
        end else begin
            req_q     <= req_in;
            pending_q <= pending_d;
        end
    end

    // Grant FSM: the presented index never changes until it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eligible != '0) begin
                        out_idx_q   <= hi_idx(eligible);
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (next_vec != '0) begin
                            out_idx_q <= hi_idx(next_vec);
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

`ifdef REQ_PEND_OVF_DETECT_EN
    logic [N-1:0] ovf_q;
    logic [N-1:0] ovf_d;

    // A new edge on a bit that is still pending (and not leaving this cycle) is an overflow; new overflow beats clear.
    always_comb begin
        ovf_d = (ovf_clr ? '0 : ovf_q) | (rise & pending_q & ~clr_vec);
    end

    // Sticky overflow flags.
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= '0;
        else     ovf_q <= ovf_d;
    end

    assign ovf_flags = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_flags      = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pend_vec  = eligible;

endmodule
